// File: rtl/muldiv_pkg.sv
// Shared opcode encodings, FSM state type and signedness helpers for the
// iterative RV32M multiply/divide sequencer.
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  function automatic logic sign_a(input logic [2:0] f3);
    return (f3 != F3_MULHU) && (f3 != F3_DIVU) && (f3 != F3_REMU);
  endfunction

  function automatic logic sign_b(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_addsub.sv
// Shared (XLEN+1)-bit adder/subtractor: multiply accumulate, divide trial
// subtract and final two's-complement negation. Carry-out means "no borrow" on sub.
module muldiv_addsub #(
  parameter int W = 33
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] sum,
  output logic         cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b ^ {W{sub}}} + {{W{1'b0}}, sub};

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M multiply/divide unit: magnitude shift-add multiply and
// restoring divide over XLEN cycles, with a sign fix-up step and Busy/Done handshake.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Start,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  input  logic            Flush,
  output logic            Busy,
  output logic            Done,
  output logic [XLEN-1:0] Result
);

  localparam int              CW     = $clog2(XLEN);
  localparam logic [CW-1:0]   LAST_C = CW'(XLEN - 1);
  localparam logic [CW-1:0]   CONE_C = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] ZERO_C = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] ONES_C = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] ONE_C  = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] MIN_C  = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state_r;
  logic [XLEN-1:0]   hi_r, lo_r, a_mag_r, b_mag_r;
  logic [2:0]        op_r;
  logic              neg_r;
  logic [CW-1:0]     count_r;

  logic              a_neg_s, b_neg_s, neg_s, div_zero_s, ovf_s, fast_s;
  logic [XLEN-1:0]   abs_a_s, abs_b_s, fast_res_s, fix_sel_s, fix_res_s;
  logic              use_lo_s;
  logic [XLEN:0]     add_a_s, add_b_s, add_sum_s;
  logic              add_sub_s, add_cout_s;

  muldiv_addsub #(.W(XLEN + 1)) u_addsub (
    .a    (add_a_s),
    .b    (add_b_s),
    .sub  (add_sub_s),
    .sum  (add_sum_s),
    .cout (add_cout_s)
  );

  // Operand magnitudes, result sign and fast-path decode for an incoming Start
  always_comb begin
    a_neg_s    = sign_a(Funct3) & SrcA[XLEN-1];
    b_neg_s    = sign_b(Funct3) & SrcB[XLEN-1];
    abs_a_s    = a_neg_s ? (~SrcA + ONE_C) : SrcA;
    abs_b_s    = b_neg_s ? (~SrcB + ONE_C) : SrcB;
    // Remainder follows the dividend; everything else follows the operand sign mix
    neg_s      = (Funct3[2] & Funct3[1]) ? a_neg_s : (a_neg_s ^ b_neg_s);
    div_zero_s = Funct3[2] & (SrcB == ZERO_C);
    ovf_s      = Funct3[2] & ~Funct3[0] & (SrcA == MIN_C) & (SrcB == ONES_C);
    fast_s     = div_zero_s | ovf_s;
    if (div_zero_s) begin
      fast_res_s = Funct3[1] ? SrcA : ONES_C;
    end else if (ovf_s) begin
      fast_res_s = Funct3[1] ? ZERO_C : MIN_C;
    end else begin
      fast_res_s = ZERO_C;
    end
  end

  // Adder operand steering: accumulate, trial subtract, or negate in FIX
  always_comb begin
    add_a_s   = {(XLEN+1){1'b0}};
    add_b_s   = {(XLEN+1){1'b0}};
    add_sub_s = 1'b0;
    case (state_r)
      ST_FIX: begin
        add_b_s   = {1'b0, fix_sel_s};
        add_sub_s = 1'b1;
      end
      default: begin
        if (!op_r[2]) begin
          add_a_s = {1'b0, hi_r};
          add_b_s = lo_r[0] ? {1'b0, a_mag_r} : {(XLEN+1){1'b0}};
        end else begin
          add_a_s   = {hi_r, lo_r[XLEN-1]};
          add_b_s   = {1'b0, b_mag_r};
          add_sub_s = 1'b1;
        end
      end
    endcase
  end

  // Sign correction: the high half of a negated product only borrows when the low half is zero
  always_comb begin
    use_lo_s  = (op_r == F3_MUL) | (op_r[2] & ~op_r[1]);
    fix_sel_s = use_lo_s ? lo_r : hi_r;
    if (!neg_r) begin
      fix_res_s = fix_sel_s;
    end else if (op_r[2] | use_lo_s | (lo_r == ZERO_C)) begin
      fix_res_s = add_sum_s[XLEN-1:0];
    end else begin
      fix_res_s = ~hi_r;
    end
  end

  // Sequencer FSM with operand/accumulator registers and registered handshake outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      hi_r    <= ZERO_C;
      lo_r    <= ZERO_C;
      a_mag_r <= ZERO_C;
      b_mag_r <= ZERO_C;
      op_r    <= 3'b000;
      neg_r   <= 1'b0;
      count_r <= {CW{1'b0}};
      Busy    <= 1'b0;
      Done    <= 1'b0;
      Result  <= ZERO_C;
    end else begin
      case (state_r)
        ST_IDLE: begin
          Done <= 1'b0;
          if (Start && !Flush) begin
            op_r    <= Funct3;
            a_mag_r <= abs_a_s;
            b_mag_r <= abs_b_s;
            neg_r   <= neg_s;
            count_r <= {CW{1'b0}};
            hi_r    <= ZERO_C;
            lo_r    <= Funct3[2] ? abs_a_s : abs_b_s;
            if (fast_s) begin
              Result  <= fast_res_s;
              Done    <= 1'b1;
              state_r <= ST_DONE;
            end else begin
              Busy    <= 1'b1;
              state_r <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (Flush) begin
            Busy    <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            if (!op_r[2]) begin
              hi_r <= add_sum_s[XLEN:1];
              lo_r <= {add_sum_s[0], lo_r[XLEN-1:1]};
            end else if (add_cout_s) begin
              hi_r <= add_sum_s[XLEN-1:0];
              lo_r <= {lo_r[XLEN-2:0], 1'b1};
            end else begin
              hi_r <= {hi_r[XLEN-2:0], lo_r[XLEN-1]};
              lo_r <= {lo_r[XLEN-2:0], 1'b0};
            end
            count_r <= count_r + CONE_C;
            if (count_r == LAST_C) begin
              state_r <= ST_FIX;
            end
          end
        end
        ST_FIX: begin
          Busy <= 1'b0;
          if (Flush) begin
            state_r <= ST_IDLE;
          end else begin
            Result  <= fix_res_s;
            Done    <= 1'b1;
            state_r <= ST_DONE;
          end
        end
        ST_DONE: begin
          Done    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          Busy    <= 1'b0;
          Done    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed table, corner sequences
// (flush, reset mid-op, fast path) and random ops against a 64-bit arithmetic model.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [2:0]  Funct3;
  logic [31:0] SrcA, SrcB;
  logic        Flush;
  logic        Busy, Done;
  logic [31:0] Result;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] held_exp;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[12];

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .Start  (Start),
    .Funct3 (Funct3),
    .SrcA   (SrcA),
    .SrcB   (SrcB),
    .Flush  (Flush),
    .Busy   (Busy),
    .Done   (Done),
    .Result (Result)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'h0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 32'h0) return 32'hFFFFFFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 32'h0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 32'h0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (!f3[2]) return 1'b0;
    if (b == 32'h0) return 1'b1;
    return (f3 == 3'd4 || f3 == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF;
  endfunction

  // Launch one op, wait (bounded) for Done, check latency, result and hold behaviour
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input bit flush_in_done, input string nm);
    int n;
    int exp_lat;
    exp_lat = is_fast(f3, a, b) ? 0 : 33;
    @(negedge clk);
    Start = 1'b1; Funct3 = f3; SrcA = a; SrcB = b;
    @(posedge clk); #1;
    Start = 1'b0;
    check({nm, " busy_after_start"}, {31'h0, Busy}, (exp_lat != 0) ? 32'h1 : 32'h0);
    n = 0;
    while (Done !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check({nm, " latency"}, n, exp_lat);
    check({nm, " result"}, Result, exp);
    check({nm, " busy_at_done"}, {31'h0, Busy}, 32'h0);
    if (flush_in_done) Flush = 1'b1;
    @(posedge clk); #1;
    Flush = 1'b0;
    check({nm, " done_one_cycle"}, {31'h0, Done}, 32'h0);
    check({nm, " result_held"}, Result, exp);
    held_exp = exp;
  endtask

  initial begin
    tbl[0]  = '{3'd0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB};
    tbl[1]  = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000};
    tbl[2]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    tbl[3]  = '{3'd4, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD};
    tbl[4]  = '{3'd6, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF};
    tbl[5]  = '{3'd5, 32'd100,      32'd7,        32'd14};
    tbl[6]  = '{3'd7, 32'd100,      32'd7,        32'd2};
    tbl[7]  = '{3'd5, 32'h00001234, 32'h00000000, 32'hFFFFFFFF};
    tbl[8]  = '{3'd6, 32'h00001234, 32'h00000000, 32'h00001234};
    tbl[9]  = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
    tbl[10] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000};
    tbl[11] = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};

    reset = 1'b1; Start = 1'b0; Funct3 = 3'd0; SrcA = 32'h0; SrcB = 32'h0; Flush = 1'b0;
    #12;
    check("reset busy", {31'h0, Busy}, 32'h0);
    check("reset done", {31'h0, Done}, 32'h0);
    check("reset result", Result, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      do_op(tbl[i].f3, tbl[i].a, tbl[i].b, tbl[i].exp, 1'b0, $sformatf("tbl%0d", i));
    end

    // Flush mid-MUL with Start held high, then a new Start at k+12
    @(negedge clk);
    Start = 1'b1; Funct3 = 3'd0; SrcA = 32'd5; SrcB = 32'd6;
    @(posedge clk); #1;
    check("flush busy_k", {31'h0, Busy}, 32'h1);
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
    end
    check("flush busy_k10", {31'h0, Busy}, 32'h1);
    check("flush done_k10", {31'h0, Done}, 32'h0);
    Flush = 1'b1;
    @(posedge clk); #1;
    check("flush busy_k11", {31'h0, Busy}, 32'h0);
    check("flush done_k11", {31'h0, Done}, 32'h0);
    check("flush result_kept", Result, held_exp);
    Flush = 1'b0; SrcA = 32'd9; SrcB = 32'd11;
    @(posedge clk); #1;
    Start = 1'b0;
    check("restart busy", {31'h0, Busy}, 32'h1);
    for (int i = 0; i < 40 && Done !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    check("restart done", {31'h0, Done}, 32'h1);
    check("restart result", Result, 32'd99);
    @(posedge clk); #1;
    held_exp = 32'd99;

    // Flush beats a simultaneous Start in IDLE, even for a fast-path op
    @(negedge clk);
    Start = 1'b1; Flush = 1'b1; Funct3 = 3'd5; SrcA = 32'h55; SrcB = 32'h0;
    @(posedge clk); #1;
    Start = 1'b0; Flush = 1'b0;
    check("idle_flush busy", {31'h0, Busy}, 32'h0);
    check("idle_flush done", {31'h0, Done}, 32'h0);
    check("idle_flush result", Result, held_exp);

    // Flush during DONE leaves the completing op intact
    do_op(3'd3, 32'h12345678, 32'h9ABCDEF0, ref_model(3'd3, 32'h12345678, 32'h9ABCDEF0), 1'b1, "flush_in_done");

    // Reset asserted mid-DIV clears everything immediately
    @(negedge clk);
    Start = 1'b1; Funct3 = 3'd4; SrcA = 32'd1000; SrcB = 32'd3;
    @(posedge clk); #1;
    Start = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    #1;
    check("midreset busy", {31'h0, Busy}, 32'h0);
    check("midreset done", {31'h0, Done}, 32'h0);
    check("midreset result", Result, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    do_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, "post_reset_mulhsu");

    // Random ops against the arithmetic model, biased toward divide corner cases
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  f3;
      logic [31:0] a, b;
      int          sel;
      f3  = 3'($urandom_range(0, 7));
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) b = 32'h0;
      else if (sel == 1) b = 32'($urandom_range(1, 15));
      else if (sel == 2) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
      else if (sel == 3) a = 32'($urandom_range(0, 255));
      do_op(f3, a, b, ref_model(f3, a, b), 1'b0, $sformatf("rnd%0d f3=%0d a=%h b=%h", i, f3, a, b));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
